// File: rtl/oserdes_stream_ser.sv
// oserdes_stream_ser: parallel word stream to single-bit serial output with an
// aligned tristate enable. One clock domain; the bit rate equals CLK.
//
// Handshake: a word transfers on a rising CLK edge where tvalid && tready.
// tready depends only on registered state (and RST), never on tvalid. The
// source may raise or drop tvalid at any time. tdata is sampled only on the
// transfer edge.
//
// The three-state FSM (IDLE/DATA/HOLD) is visible on state_dbg.
module oserdes_stream_ser #(
  parameter int   DATA_WIDTH = 8,     // 2..32
  parameter bit   MSB_FIRST  = 1'b0,  // 0: tdata[0] first, 1: tdata[DATA_WIDTH-1] first
  parameter logic IDLE_VALUE = 1'b0,  // OQ level when no data bit is on the line
  parameter int   T_HOLD     = 0      // 0..15 driven idle bit-times after a burst
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  output logic                  tready,
  output logic                  OQ,
  output logic                  T_OUT,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [3:0]       HOLD_INIT = (T_HOLD > 0) ? 4'(T_HOLD - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DATA = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] sr;        // bits still to be sent, next bit at the exit end
  logic [CNT_W-1:0]      cnt;       // index of the bit currently on OQ
  logic [3:0]            hold_cnt;  // remaining hold cycles after the current one

  logic                  last_bit;
  logic                  accept;
  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] sr_load;
  logic [DATA_WIDTH-1:0] sr_shift;

  // Handshake and bit-order selection, all from registered state.
  always_comb begin
    last_bit = (state == ST_DATA) && (cnt == CNT_LAST);
    tready   = !RST && ((state == ST_IDLE) || (state == ST_HOLD) || last_bit);
    accept   = tvalid && tready;
    if (MSB_FIRST) begin
      // The first bit goes straight to OQ, so sr keeps the word pre-shifted.
      first_bit = tdata[DATA_WIDTH-1];
      sr_load   = tdata << 1;
      next_bit  = sr[DATA_WIDTH-1];
      sr_shift  = sr << 1;
    end else begin
      first_bit = tdata[0];
      sr_load   = tdata >> 1;
      next_bit  = sr[0];
      sr_shift  = sr >> 1;
    end
  end

  // FSM, datapath and registered pin outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      sr       <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
      OQ       <= IDLE_VALUE;
      T_OUT    <= 1'b1;
    end else if (accept) begin
      // Accept wins in every state: this is what makes back-to-back words
      // seamless and lets a new word cut a hold window short.
      state    <= ST_DATA;
      sr       <= sr_load;
      cnt      <= '0;
      hold_cnt <= '0;
      OQ       <= first_bit;
      T_OUT    <= 1'b0;
    end else begin
      case (state)
        ST_DATA: begin
          if (last_bit) begin
            cnt <= '0;
            OQ  <= IDLE_VALUE;
            if (T_HOLD > 0) begin
              state    <= ST_HOLD;
              hold_cnt <= HOLD_INIT;
              T_OUT    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              T_OUT <= 1'b1;
            end
          end else begin
            OQ  <= next_bit;
            sr  <= sr_shift;
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          OQ <= IDLE_VALUE;
          if (hold_cnt == 4'd0) begin
            state <= ST_IDLE;
            T_OUT <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
            T_OUT    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          OQ    <= IDLE_VALUE;
          T_OUT <= 1'b1;
        end
      endcase
    end
  end

  // Status outputs decoded from the FSM.
  always_comb begin
    busy      = (state == ST_DATA) || (state == ST_HOLD);
    state_dbg = state;
  end

endmodule

// File: tb/tb_oserdes_stream_ser.sv
// Directed bench for oserdes_stream_ser: four instances cover LSB-first,
// MSB-first, hold window with idle-high, and a 4-bit word width.
module tb_oserdes_stream_ser;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0] tdata_a, tdata_m, tdata_h;
  logic [3:0] tdata_4;
  logic tvalid_a, tvalid_m, tvalid_h, tvalid_4;
  logic tready_a, tready_m, tready_h, tready_4;
  logic oq_a, oq_m, oq_h, oq_4;
  logic t_a, t_m, t_h, t_4;
  logic busy_a, busy_m, busy_h, busy_4;
  logic [1:0] st_a, st_m, st_h, st_4;

  oserdes_stream_ser #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b0), .T_HOLD(0)) dut_a (
    .CLK(clk), .RST(rst), .tdata(tdata_a), .tvalid(tvalid_a), .tready(tready_a),
    .OQ(oq_a), .T_OUT(t_a), .busy(busy_a), .state_dbg(st_a));

  oserdes_stream_ser #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VALUE(1'b0), .T_HOLD(0)) dut_m (
    .CLK(clk), .RST(rst), .tdata(tdata_m), .tvalid(tvalid_m), .tready(tready_m),
    .OQ(oq_m), .T_OUT(t_m), .busy(busy_m), .state_dbg(st_m));

  oserdes_stream_ser #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b1), .T_HOLD(3)) dut_h (
    .CLK(clk), .RST(rst), .tdata(tdata_h), .tvalid(tvalid_h), .tready(tready_h),
    .OQ(oq_h), .T_OUT(t_h), .busy(busy_h), .state_dbg(st_h));

  oserdes_stream_ser #(.DATA_WIDTH(4), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b0), .T_HOLD(0)) dut_4 (
    .CLK(clk), .RST(rst), .tdata(tdata_4), .tvalid(tvalid_4), .tready(tready_4),
    .OQ(oq_4), .T_OUT(t_4), .busy(busy_4), .state_dbg(st_4));

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue n expected OQ bits; seq is written in the order they appear on the line.
  task automatic push_seq(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[n-1-i]);
  endtask

  function automatic logic pop_exp();
    logic [0:0] b;
    if (exp_q.size() == 0) begin
      b = 1'bx;
    end else begin
      b = exp_q.pop_front();
    end
    return b;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    tdata_a = '0; tdata_m = '0; tdata_h = '0; tdata_4 = '0;
    tvalid_a = 1'b0; tvalid_m = 1'b0; tvalid_h = 1'b0; tvalid_4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset values while RST is held
    check("rst_oq_a", oq_a, 1'b0);
    check("rst_t_a", t_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_tready_a", tready_a, 1'b0);
    check("rst_st_a", st_a, 2'b00);
    check("rst_oq_h", oq_h, 1'b1);
    check("rst_t_h", t_h, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready_a", tready_a, 1'b1);

    // Single word A5, LSB first; tdata changed after accept must not matter
    tdata_a = 8'hA5; tvalid_a = 1'b1;
    @(posedge clk); #1 tvalid_a = 1'b0; tdata_a = 8'hFF;
    push_seq(16'b1010_0101, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a5_oq", oq_a, pop_exp());
      check("a5_t", t_a, 1'b0);
      check("a5_busy", busy_a, 1'b1);
      check("a5_tready", tready_a, (i == 7) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("a5_end_t", t_a, 1'b1);
    check("a5_end_oq", oq_a, 1'b0);
    check("a5_end_busy", busy_a, 1'b0);

    // Back-to-back FF then 00 with tvalid held high
    tdata_a = 8'hFF; tvalid_a = 1'b1;
    @(posedge clk); #1 tdata_a = 8'h00;
    push_seq(16'hFF00, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("b2b_oq", oq_a, pop_exp());
      check("b2b_t", t_a, 1'b0);
      if (i == 3) check("b2b_tready_mid", tready_a, 1'b0);
      if (i == 7) begin
        check("b2b_tready_last", tready_a, 1'b1);
        @(posedge clk); #1 tvalid_a = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_t", t_a, 1'b1);

    // MSB first, C0
    tdata_m = 8'hC0; tvalid_m = 1'b1;
    @(posedge clk); #1 tvalid_m = 1'b0;
    push_seq(16'b1100_0000, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("msb_oq", oq_m, pop_exp());
      check("msb_t", t_m, 1'b0);
    end
    @(negedge clk);
    check("msb_end_t", t_m, 1'b1);

    // Hold window: 3C then three driven idle-high cycles
    tdata_h = 8'h3C; tvalid_h = 1'b1;
    @(posedge clk); #1 tvalid_h = 1'b0;
    push_seq(16'b0011_1100, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("hold_oq", oq_h, pop_exp());
      check("hold_t", t_h, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_win_oq", oq_h, 1'b1);
      check("hold_win_t", t_h, 1'b0);
      check("hold_win_busy", busy_h, 1'b1);
      check("hold_win_tready", tready_h, 1'b1);
      check("hold_win_st", st_h, 2'b10);
    end
    @(negedge clk);
    check("hold_end_t", t_h, 1'b1);
    check("hold_end_busy", busy_h, 1'b0);
    check("hold_end_oq", oq_h, 1'b1);

    // Hold window cut short by a word offered in the second hold cycle
    tdata_h = 8'h3C; tvalid_h = 1'b1;
    @(posedge clk); #1 tvalid_h = 1'b0;
    push_seq(16'b0011_1100, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cut_oq", oq_h, pop_exp());
    end
    @(negedge clk);
    check("cut_h1_oq", oq_h, 1'b1);
    check("cut_h1_t", t_h, 1'b0);
    @(posedge clk); #1 tdata_h = 8'h80; tvalid_h = 1'b1;
    @(negedge clk);
    check("cut_h2_t", t_h, 1'b0);
    check("cut_h2_tready", tready_h, 1'b1);
    @(posedge clk); #1 tvalid_h = 1'b0;
    push_seq(16'b0000_0001, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cut_w2_oq", oq_h, pop_exp());
      check("cut_w2_t", t_h, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cut_w2_hold_oq", oq_h, 1'b1);
      check("cut_w2_hold_t", t_h, 1'b0);
    end
    @(negedge clk);
    check("cut_w2_end_t", t_h, 1'b1);

    // Reset mid-word (5A, after 3 bits); a word offered during RST is refused
    tdata_a = 8'h5A; tvalid_a = 1'b1;
    @(posedge clk); #1 tvalid_a = 1'b0;
    push_seq(16'b0101_1010, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmid_oq", oq_a, pop_exp());
    end
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1; tdata_a = 8'hFF; tvalid_a = 1'b1;
    @(negedge clk);
    check("rmid_tready_rst", tready_a, 1'b0);
    @(posedge clk); #1 rst = 1'b0; tvalid_a = 1'b0;
    @(negedge clk);
    check("rmid_oq_after", oq_a, 1'b0);
    check("rmid_t_after", t_a, 1'b1);
    check("rmid_busy_after", busy_a, 1'b0);
    check("rmid_tready_after", tready_a, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rmid_quiet_oq", oq_a, 1'b0);
      check("rmid_quiet_t", t_a, 1'b1);
    end

    // No input on the 4-bit instance
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle4_oq", oq_4, 1'b0);
      check("idle4_t", t_4, 1'b1);
      check("idle4_tready", tready_4, 1'b1);
    end

    // One 4-bit word, B
    tdata_4 = 4'hB; tvalid_4 = 1'b1;
    @(posedge clk); #1 tvalid_4 = 1'b0;
    push_seq(16'b1101, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w4_oq", oq_4, pop_exp());
      check("w4_t", t_4, 1'b0);
      check("w4_tready", tready_4, (i == 3) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("w4_end_t", t_4, 1'b1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
